// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares the single MMU data port between the
// CPU load/store unit (m0) and the debug/DMA loader (m1).
module dm_port_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m0_signed,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    input  logic        m1_signed,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_di,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic        is_signed,
    input  logic [31:0] dm_do
);

    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW:0]   BURST_LIM = (BW + 1)'(MAX_BURST);

    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] burst_cnt;
    logic [BW:0]   burst_inc;
    logic          lock_active;
    logic          last_src;
    logic          unused_last_src;

    // last_src is a debug tap only; nothing downstream consumes it
    assign unused_last_src = last_src;

    assign burst_inc = {1'b0, burst_cnt} + (BW + 1)'(1);

    // Fixed-priority grant: lock, starvation force, m0, then m1
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (resetb) begin
            if (lock_active && m1_req) begin
                m1_gnt = 1'b1;
            end else if (m1_req && (wait_cnt == WAIT_MAX)) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    // Steer the granted requester onto the MMU port; strobes low when idle
    always_comb begin
        dm_addr   = m1_gnt ? m1_addr   : m0_addr;
        dm_di     = m1_gnt ? m1_wdata  : m0_wdata;
        is_signed = m1_gnt ? m1_signed : m0_signed;
        dm_we     = (m0_gnt & m0_we) | (m1_gnt & m1_we);
        dm_be     = ({4{m0_gnt}} & m0_be) | ({4{m1_gnt}} & m1_be);
    end

    assign m0_rdata = dm_do;
    assign m1_rdata = dm_do;

    // Starvation/burst counters, lock state and read-response tracking
    always_ff @(posedge clk) begin
        if (!resetb) begin
            wait_cnt    <= '0;
            burst_cnt   <= '0;
            lock_active <= 1'b0;
            last_src    <= 1'b0;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
        end else begin
            if (!m1_req || m1_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            if (m1_gnt && m1_lock) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
            end else begin
                burst_cnt <= '0;
            end

            lock_active <= m1_gnt && m1_lock && (burst_inc < BURST_LIM);

            if (m0_gnt || m1_gnt) begin
                last_src <= m1_gnt;
            end

            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter.
// Inputs change 1ns after posedge, outputs are checked 1ns later.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        resetb;
    logic        m0_req, m0_we, m0_signed;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_be;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_signed, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_be;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] dm_addr, dm_di, dm_do;
    logic        dm_we, is_signed;
    logic [3:0]  dm_be;

    int n_cmp = 0;
    int n_bad = 0;

    dm_port_arbiter #(.MAX_WAIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .resetb(resetb),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_signed(m0_signed),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_signed(m1_signed),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_di(dm_di), .dm_we(dm_we), .dm_be(dm_be),
        .is_signed(is_signed), .dm_do(dm_do)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m0_be = 0; m0_signed = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        m1_be = 0; m1_signed = 0; m1_lock = 0;
        dm_do = 0;
    endtask

    initial begin
        idle();
        resetb = 0;
        // requests during reset must not be granted
        m0_req = 1; m0_we = 1; m0_be = 4'hF;
        m1_req = 1;
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_dm_be", dm_be, 0);
        cyc();
        cyc();
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);

        // idle after release
        resetb = 1;
        idle();
        #1;
        chk("idle_m0_gnt", m0_gnt, 0);
        chk("idle_m1_gnt", m1_gnt, 0);
        chk("idle_dm_we", dm_we, 0);
        chk("idle_dm_be", dm_be, 0);
        cyc();
        chk("idle_m0_rvalid", m0_rvalid, 0);
        chk("idle_m1_rvalid", m1_rvalid, 0);

        // m0 single read
        m0_req = 1; m0_we = 0; m0_addr = 32'h1000_0004; m0_be = 4'hF;
        #1;
        chk("rd_m0_gnt", m0_gnt, 1);
        chk("rd_m1_gnt", m1_gnt, 0);
        chk("rd_dm_addr", dm_addr, 32'h1000_0004);
        chk("rd_dm_be", dm_be, 4'hF);
        chk("rd_dm_we", dm_we, 0);
        cyc();
        idle();
        dm_do = 32'hDEAD_BEEF;
        #1;
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        chk("rd_m0_gnt_after", m0_gnt, 0);

        // m0 single byte write
        cyc();
        m0_req = 1; m0_we = 1; m0_addr = 32'h8000_0010;
        m0_be = 4'b0001; m0_wdata = 32'h0000_0055;
        #1;
        chk("wr_dm_we", dm_we, 1);
        chk("wr_dm_be", dm_be, 4'b0001);
        chk("wr_dm_di", dm_di, 32'h0000_0055);
        chk("wr_dm_addr", dm_addr, 32'h8000_0010);
        cyc();
        idle();
        #1;
        chk("wr_dm_we_after", dm_we, 0);
        chk("wr_dm_be_after", dm_be, 0);
        chk("wr_m0_rvalid", m0_rvalid, 0);

        // continuous contention: 4 m0 grants then 1 forced m1 grant
        for (int i = 0; i < 10; i++) begin
            cyc();
            m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100;
            m0_be = 4'hF; m0_signed = 0;
            m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0200;
            m1_be = 4'hF; m1_signed = 1; m1_lock = 0;
            #1;
            chk("rr_m0_gnt", m0_gnt, (i % 5) != 4);
            chk("rr_m1_gnt", m1_gnt, (i % 5) == 4);
            chk("rr_is_signed", is_signed, (i % 5) == 4);
            chk("rr_dm_addr", dm_addr,
                ((i % 5) == 4) ? 32'h0000_0200 : 32'h0000_0100);
            chk("rr_m1_rvalid", m1_rvalid, (i > 0) && ((i - 1) % 5 == 4));
            chk("rr_m0_rvalid", m0_rvalid, (i > 0) && ((i - 1) % 5 != 4));
        end
        cyc();
        idle();
        #1;
        chk("rr_m1_rvalid_last", m1_rvalid, 1);

        // locked m1 write burst of MAX_BURST, m0 waits then wins
        cyc();
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_be = 4'hF;
        m1_addr = 32'h0000_0400;
        #1;
        chk("bu_m1_gnt_1", m1_gnt, 1);
        for (int k = 2; k <= 8; k++) begin
            cyc();
            m0_req = 1; m0_we = 0; m0_be = 4'hF;
            #1;
            chk("bu_m1_gnt", m1_gnt, 1);
            chk("bu_m0_gnt", m0_gnt, 0);
            chk("bu_dm_we", dm_we, 1);
            chk("bu_m1_rvalid", m1_rvalid, 0);
        end
        cyc();
        #1;
        chk("bu_m0_gnt_end", m0_gnt, 1);
        chk("bu_m1_gnt_end", m1_gnt, 0);
        chk("bu_m1_rvalid_end", m1_rvalid, 0);
        cyc();
        idle();
        #1;
        chk("bu_m1_rvalid_idle", m1_rvalid, 0);

        // lock dropped on the third m1 grant, m0 pending
        cyc();
        m1_req = 1; m1_we = 0; m1_lock = 1; m1_be = 4'hF;
        #1;
        chk("ld_m1_gnt_1", m1_gnt, 1);
        cyc();
        m0_req = 1; m0_we = 0; m0_be = 4'hF;
        #1;
        chk("ld_m1_gnt_2", m1_gnt, 1);
        cyc();
        m1_lock = 0;
        #1;
        chk("ld_m1_gnt_3", m1_gnt, 1);
        chk("ld_m0_gnt_3", m0_gnt, 0);
        cyc();
        #1;
        chk("ld_m0_gnt_4", m0_gnt, 1);
        chk("ld_m1_gnt_4", m1_gnt, 0);
        cyc();
        idle();

        // forced m1 read, then reset with a response in flight
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_req = 1; m0_we = 0; m0_be = 4'hF;
            m1_req = 1; m1_we = 0; m1_be = 4'hF; m1_lock = 0;
            #1;
            chk("rs_m0_gnt_pre", m0_gnt, 1);
        end
        cyc();
        #1;
        chk("rs_m1_forced", m1_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            resetb = 0;
            #1;
            chk("rs_m0_gnt_rst", m0_gnt, 0);
            chk("rs_m1_gnt_rst", m1_gnt, 0);
            chk("rs_dm_we_rst", dm_we, 0);
            chk("rs_dm_be_rst", dm_be, 0);
            if (i > 0) chk("rs_m1_rvalid_rst", m1_rvalid, 0);
        end
        cyc();
        resetb = 1;
        #1;
        chk("rs_m1_rvalid_rel", m1_rvalid, 0);
        chk("rs_m0_gnt_rel", m0_gnt, 1);
        chk("rs_m1_gnt_rel", m1_gnt, 0);
        cyc();
        idle();
        #1;
        chk("rs_m0_rvalid_rel", m0_rvalid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
